// File: rtl/mem_arbiter.sv
// Shared RAM port arbiter between instruction fetch and data memory; D wins by default.
// Optional macro STARVE_GUARD_EN bounds how long a pending fetch can be starved by data traffic.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LAT_MAX    = 15,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] iload,
    output logic              ihit,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic [DATA_W-1:0] dload,
    output logic              dhit,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              err
);

    localparam int CNT_W = ($clog2(LAT_MAX + 1) < 4) ? 4 : $clog2(LAT_MAX + 1);
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    if (LAT_MAX < 2 || STARVE_MAX < 1) begin : g_bad_param
        $error("mem_arbiter: LAT_MAX must be >= 2 and STARVE_MAX >= 1");
    end

    typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

    state_t           state, next;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             err_set;
    logic             dreq;
    logic             i_first;
    logic             tmo;

    assign dreq = dREN | dWEN;
    // Last allowed grant cycle: counter starts at 0 on the first grant cycle.
    assign tmo  = (cnt == CNT_W'(LAT_MAX - 1)) || (ramstate == RS_ERROR);

`ifdef STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] starve_cnt;

    assign i_first = iREN && (starve_cnt == SW'(STARVE_MAX));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            starve_cnt <= '0;
        else if (!iREN || (state == IDLE && next == IGNT))
            starve_cnt <= '0;
        else if (dhit && starve_cnt != SW'(STARVE_MAX))
            starve_cnt <= starve_cnt + 1'b1;
    end
`else
    assign i_first = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            state <= next;
            cnt   <= cnt_nxt;
            err   <= err | err_set;
        end
    end

    always_comb begin
        next     = state;
        cnt_nxt  = cnt;
        err_set  = 1'b0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        ihit     = 1'b0;
        dhit     = 1'b0;
        iload    = '0;
        dload    = '0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (i_first)   next = IGNT;
                else if (dreq) next = DGNT;
                else if (iREN) next = IGNT;
            end
            IGNT: begin
                // A dropped request is a pipeline flush: release the port quietly.
                if (!iREN) begin
                    next = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (ramstate == RS_ACCESS) begin
                        ihit  = 1'b1;
                        iload = ramload;
                        next  = IDLE;
                    end else if (tmo) begin
                        err_set = 1'b1;
                        next    = IDLE;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            DGNT: begin
                if (!dreq) begin
                    next = IDLE;
                end else begin
                    ramREN   = dREN & ~dWEN;
                    ramWEN   = dWEN;
                    ramaddr  = daddr;
                    ramstore = dstore;
                    if (dREN && dWEN) err_set = 1'b1;
                    if (ramstate == RS_ACCESS) begin
                        dhit  = 1'b1;
                        dload = ramload;
                        next  = IDLE;
                    end else if (tmo) begin
                        err_set = 1'b1;
                        next    = IDLE;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            default: next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected hits queued at stimulus time, popped on ihit/dhit.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic        ihit, dhit, ramREN, ramWEN, err;
    logic [1:0]  ramstate;

    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2;

    int checks   = 0;
    int failures = 0;
    int ihit_cnt;

    typedef struct {
        logic        d;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT_MAX(15), .STARVE_MAX(4)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dhit(dhit),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_hit(input logic d, input logic [31:0] data);
        exp_t e;
        e.d    = d;
        e.data = data;
        sb.push_back(e);
    endtask

    always @(negedge CLK) begin
        if (ihit || dhit) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_hit", {62'd0, ihit, dhit}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_both_hits", {63'd0, ihit & dhit}, 64'd0);
                chk("sb_side", {63'd0, dhit}, {63'd0, mon_e.d});
                chk("sb_data", {32'd0, mon_e.d ? dload : iload}, {32'd0, mon_e.data});
            end
        end else begin
            chk("load_zero_no_hit", {iload, dload}, 64'd0);
        end
    end

    initial begin
        RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = 32'hFFFF_FFFF; ramstate = FREE;
        tick; tick;
        chk("rst_ramREN", ramREN, 0);
        chk("rst_ramWEN", ramWEN, 0);
        chk("rst_ramaddr", ramaddr, 0);
        chk("rst_hits", {ihit, dhit}, 0);
        chk("rst_err", err, 0);
        RST = 1'b0;
        tick;

        // fetch answered on the first grant cycle
        iREN = 1; iaddr = 32'h40; ramstate = ACCESS; ramload = 32'h2002_0001;
        expect_hit(0, 32'h2002_0001);
        #1 chk("t1_c0_nostrobe", ramREN, 0);
        tick;
        chk("t1_ramREN", ramREN, 1);
        chk("t1_ramaddr", ramaddr, 32'h40);
        chk("t1_ihit", ihit, 1);
        chk("t1_iload", iload, 32'h2002_0001);
        tick; iREN = 0; ramstate = FREE;
        #1 chk("t1_idle", {ramREN, ihit}, 0);

        // simultaneous I and D write: D first, I after turnaround
        iREN = 1; iaddr = 32'h44; dWEN = 1; daddr = 32'h80; dstore = 32'hDEAD_BEEF;
        ramstate = ACCESS; ramload = 32'h1111_2222;
        expect_hit(1, 32'h1111_2222);
        expect_hit(0, 32'h1111_2222);
        tick;
        chk("t2_ramWEN", ramWEN, 1);
        chk("t2_ramREN", ramREN, 0);
        chk("t2_ramaddr", ramaddr, 32'h80);
        chk("t2_ramstore", ramstore, 32'hDEAD_BEEF);
        chk("t2_dhit", dhit, 1);
        tick; dWEN = 0;
        #1 chk("t2_turnaround", {ramREN, ramWEN}, 0);
        tick;
        chk("t2_i_ramREN", ramREN, 1);
        chk("t2_i_ramaddr", ramaddr, 32'h44);
        chk("t2_ihit", ihit, 1);
        tick; iREN = 0; ramstate = FREE;

        // three BUSY cycles, then ACCESS
        dREN = 1; daddr = 32'h100; ramstate = BUSY; ramload = 32'h0BAD_0BAD;
        expect_hit(1, 32'hCAFE_0003);
        for (int k = 1; k <= 3; k++) begin
            tick;
            chk("t3_busy_ramREN", ramREN, 1);
            chk("t3_busy_dhit", dhit, 0);
        end
        tick; ramstate = ACCESS; ramload = 32'hCAFE_0003;
        #1 chk("t3_dhit", dhit, 1);
        chk("t3_dload", dload, 32'hCAFE_0003);
        tick; dREN = 0; ramstate = FREE;
        #1 chk("t3_single_pulse", dhit, 0);

        // flush aborts a fetch in its second grant cycle
        iREN = 1; iaddr = 32'h48; ramstate = BUSY;
        tick;
        chk("t4_c1_ramREN", ramREN, 1);
        tick; iREN = 0;
        #1 chk("t4_abort_strobe", ramREN, 0);
        chk("t4_abort_ihit", ihit, 0);
        tick; iREN = 1; ramstate = ACCESS; ramload = 32'h4444_0004;
        #1 chk("t4_idle_after_abort", {ramREN, ihit}, 0);
        expect_hit(0, 32'h4444_0004);
        tick;
        chk("t4_refetch_ihit", ihit, 1);
        tick; iREN = 0; ramstate = FREE;
        chk("t4_err_clean", err, 0);

        // stuck BUSY: timeout after 15 grant cycles, then retry
        iREN = 1; iaddr = 32'h4C; ramstate = BUSY;
        for (int k = 1; k <= 15; k++) begin
            tick;
            chk("t5_grant_ramREN", ramREN, 1);
            chk("t5_err_pre", err, 0);
        end
        tick;
        chk("t5_err_set", err, 1);
        chk("t5_turnaround", ramREN, 0);
        tick;
        chk("t5_retry_ramREN", ramREN, 1);
        chk("t5_retry_ramaddr", ramaddr, 32'h4C);
        ramstate = ACCESS; ramload = 32'h5555_0005;
        expect_hit(0, 32'h5555_0005);
        #1 chk("t5_retry_ihit", ihit, 1);
        tick; iREN = 0; ramstate = FREE;
        #1 chk("t5_err_sticky", err, 1);
        tick;
        chk("t5_err_sticky2", err, 1);
        RST = 1;
        #1 chk("t5_err_rst", err, 0);
        tick; RST = 0;
        tick;

        // reset in the middle of a grant
        iREN = 1; iaddr = 32'h60; ramstate = BUSY;
        tick;
        chk("t6_ramREN", ramREN, 1);
        RST = 1; ramstate = ACCESS;
        #1 chk("t6_rst_strobe", ramREN, 0);
        chk("t6_rst_ihit", ihit, 0);
        tick; iREN = 0; RST = 0; ramstate = FREE;
        tick;

        // read and write together: write wins, err raised
        dREN = 1; dWEN = 1; daddr = 32'h90; dstore = 32'h1234_5678;
        ramstate = ACCESS; ramload = 32'h7777_0007;
        expect_hit(1, 32'h7777_0007);
        tick;
        chk("t7_ramWEN", ramWEN, 1);
        chk("t7_ramREN", ramREN, 0);
        chk("t7_ramstore", ramstore, 32'h1234_5678);
        chk("t7_dhit", dhit, 1);
        tick; dREN = 0; dWEN = 0; ramstate = FREE;
        #1 chk("t7_err", err, 1);
        RST = 1;
        tick; RST = 0;
        tick;

        // continuous D and I traffic
        ramload = 32'h5A5A_5A5A; ramstate = ACCESS;
        dREN = 1; daddr = 32'hA0; iREN = 1; iaddr = 32'h50;
`ifdef STARVE_GUARD_EN
        for (int k = 0; k < 4; k++) expect_hit(1, 32'h5A5A_5A5A);
        expect_hit(0, 32'h5A5A_5A5A);
`else
        for (int k = 0; k < 5; k++) expect_hit(1, 32'h5A5A_5A5A);
`endif
        ihit_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            tick;
            ihit_cnt += int'(ihit);
        end
`ifdef STARVE_GUARD_EN
        chk("t8_ihits", ihit_cnt, 1);
`else
        chk("t8_ihits", ihit_cnt, 0);
`endif
        dREN = 0; iREN = 0; ramstate = FREE;
        tick;
        chk("t8_idle", {ramREN, ramWEN}, 0);
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
